// File: rtl/instr_queue.sv
// Decoded-uop queue between decode and rename/dispatch: a circular buffer that
// accepts up to ENQ_WIDTH uops and releases up to DEQ_WIDTH uops per cycle in program order.
module instr_queue #(
  parameter  int ENTRY_WIDTH = 128,
  parameter  int DEPTH       = 16,
  parameter  int ENQ_WIDTH   = 4,
  parameter  int DEQ_WIDTH   = 4,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH + 1),
  localparam int ENQ_CW      = $clog2(ENQ_WIDTH + 1),
  localparam int DEQ_CW      = $clog2(DEQ_WIDTH + 1)
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             flush_in,
  input  logic                             enq_valid_in,
  input  logic [ENQ_CW-1:0]                enq_count_in,
  input  logic [ENQ_WIDTH*ENTRY_WIDTH-1:0] enq_data_in,
  output logic                             enq_ready_out,
  input  logic                             deq_ready_in,
  input  logic [DEQ_CW-1:0]                deq_count_in,
  output logic [DEQ_WIDTH-1:0]             deq_valid_out,
  output logic [DEQ_WIDTH*ENTRY_WIDTH-1:0] deq_data_out,
  output logic [CNT_W-1:0]                 count_out,
  output logic                             empty_out,
  output logic                             full_out
);

  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0]       free_slots;
  logic [CNT_W-1:0]       enq_n;
  logic [CNT_W-1:0]       deq_n;
  logic                   enq_fire;
  logic [ENQ_WIDTH-1:0]   wr_en;
  logic [PTR_W-1:0]       wr_addr [ENQ_WIDTH];

  // NOTE: every signal assigned in an always_comb gets a default before any
  // conditional update, so no path leaves it holding a value (no latch).
  always_comb begin
    free_slots    = CNT_W'(DEPTH) - count_q;
    // Ready looks only at registered occupancy, never at this cycle's pop.
    enq_ready_out = free_slots >= CNT_W'(ENQ_WIDTH);
    enq_fire      = enq_valid_in && enq_ready_out && !flush_in;

    enq_n = '0;
    if (enq_fire) begin
      enq_n = (enq_count_in > ENQ_CW'(ENQ_WIDTH)) ? CNT_W'(ENQ_WIDTH) : CNT_W'(enq_count_in);
    end

    deq_n = '0;
    if (deq_ready_in && !flush_in) begin
      deq_n = CNT_W'(deq_count_in);
      if (deq_n > count_q)            deq_n = count_q;
      if (deq_n > CNT_W'(DEQ_WIDTH))  deq_n = CNT_W'(DEQ_WIDTH);
    end

    // Power-of-two depth: pointer arithmetic wraps by truncation.
    head_d  = head_q + PTR_W'(deq_n);
    tail_d  = tail_q + PTR_W'(enq_n);
    count_d = count_q + enq_n - deq_n;

    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      wr_en[i]   = enq_fire && (CNT_W'(i) < enq_n);
      wr_addr[i] = tail_q + PTR_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides which
  // entries are meaningful, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (wr_en[i]) mem_q[wr_addr[i]] <= enq_data_in[i*ENTRY_WIDTH +: ENTRY_WIDTH];
    end
  end

  always_comb begin
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      deq_valid_out[i]                          = count_q > CNT_W'(i);
      deq_data_out[i*ENTRY_WIDTH +: ENTRY_WIDTH] = mem_q[head_q + PTR_W'(i)];
    end
  end

  assign count_out = count_q;
  assign empty_out = (count_q == '0);
  assign full_out  = (count_q == CNT_W'(DEPTH));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (count_q <= CNT_W'(DEPTH));
      assert ((tail_q - head_q) == count_q[PTR_W-1:0]);
      assert (!(full_out && enq_ready_out));
      if (enq_valid_in) assert (enq_count_in <= ENQ_CW'(ENQ_WIDTH));
    end
  end

endmodule
